// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered N-to-2^N one-hot decoder with a scan mode.
// Direct mode decodes i into a one-hot word on d with one cycle of latency.
// Scan mode walks the one-hot bit from index 0 up to the limit on i. Each
// index is held for SCAN_DIV cycles. A wrap pulse marks each return to 0.
// Optional build macro: DECODER_SCAN_BLANK_EN inserts one blank cycle
// (d=0, valid=0) after every scan step.
module decoder_scan_seq #(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 1 << IN_W,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [IN_W-1:0]  i,
  input  logic             i_valid,
  output logic [OUT_W-1:0] d,
  output logic             valid,
  output logic [IN_W-1:0]  idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Divider value on the last cycle an index is held.
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  state_t           state_q, state_d;
  logic [15:0]      div_q, div_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic             wrap_q, wrap_d;
`ifdef DECODER_SCAN_BLANK_EN
  logic             blank_q, blank_d;
`endif

  // Index reached at the end of the current step, and whether that step wraps.
  logic [IN_W-1:0]  adv_idx;
  logic             adv_wrap;

  // One-hot encode an index.
  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] k);
    logic [OUT_W-1:0] one;
    one    = {{(OUT_W-1){1'b0}}, 1'b1};
    onehot = one << k;
  endfunction

  // Step rule: wrap to 0 when at or past the limit, otherwise increment.
  always_comb begin
    adv_wrap = (idx_q >= i);
    if (adv_wrap) begin
      adv_idx = {IN_W{1'b0}};
    end else begin
      adv_idx = idx_q + IN_W'(1);
    end
  end

  // Next-state and next-output logic for the IDLE/DIRECT/SCAN controller.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    d_d     = d_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    blank_d = 1'b0;
`endif
    if (!en) begin
      // Disable wins over everything else.
      state_d = ST_IDLE;
      div_d   = 16'd0;
      d_d     = {OUT_W{1'b0}};
      valid_d = 1'b0;
      idx_d   = {IN_W{1'b0}};
    end else if (!mode) begin
      state_d = ST_DIRECT;
      div_d   = 16'd0;
      if (i_valid) begin
        d_d     = onehot(i);
        idx_d   = i;
        valid_d = 1'b1;
      end else if (state_q == ST_SCAN) begin
        // Leaving scan: keep showing the last scanned index as valid,
        // even if the scan was sitting in a blank cycle.
        d_d     = onehot(idx_q);
        valid_d = 1'b1;
      end else begin
        d_d     = d_q;
        valid_d = valid_q;
      end
    end else if (state_q != ST_SCAN) begin
      // Scan entry always starts from index 0 with a fresh divider.
      state_d = ST_SCAN;
      div_d   = 16'd0;
      d_d     = onehot({IN_W{1'b0}});
      idx_d   = {IN_W{1'b0}};
      valid_d = 1'b1;
    end else begin
`ifdef DECODER_SCAN_BLANK_EN
      if (blank_q) begin
        div_d   = 16'd0;
        idx_d   = adv_idx;
        d_d     = onehot(adv_idx);
        valid_d = 1'b1;
        wrap_d  = adv_wrap;
      end else if (div_q == DIV_LAST) begin
        blank_d = 1'b1;
        div_d   = 16'd0;
        d_d     = {OUT_W{1'b0}};
        valid_d = 1'b0;
      end else begin
        div_d   = div_q + 16'd1;
      end
`else
      if (div_q == DIV_LAST) begin
        div_d   = 16'd0;
        idx_d   = adv_idx;
        d_d     = onehot(adv_idx);
        valid_d = 1'b1;
        wrap_d  = adv_wrap;
      end else begin
        div_d   = div_q + 16'd1;
      end
`endif
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= 16'd0;
      d_q     <= {OUT_W{1'b0}};
      valid_q <= 1'b0;
      idx_q   <= {IN_W{1'b0}};
      wrap_q  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
`ifdef DECODER_SCAN_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;

endmodule
